// File: rtl/sccb_init_sequencer.sv
// SCCB register-init sequencer: walks a (reg, data) table and issues one single-byte write per entry
// to i2c_controller, with delay markers, NACK/timeout retry and terminator. Optional macro: SCCB_READBACK_VERIFY_EN.
module sccb_init_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h21,
  parameter int         ROM_AW         = 8,
  parameter int         MS_CYCLES      = 50000,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              m_valid,
  output logic              m_we,
  output logic [6:0]        ADDR,
  output logic [7:0]        REG,
  output logic [7:0]        DATA_IN,
  output logic [4:0]        DataNum,
  input  logic [7:0]        DATA_OUT,
  input  logic              m_ready,
  input  logic              NACK
);

  localparam int DLY_MAX = 255 * MS_CYCLES;
  localparam int CNT_MAX = (DLY_MAX > TIMEOUT_CYCLES) ? DLY_MAX : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MS_K      = CNT_W'(MS_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [ROM_AW-1:0]  LAST_IDX  = '1;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, NEXT, FINISH, FAIL
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;    // delay countdown or wait-state timeout, never both at once
  logic [RETRY_W-1:0] retry;
  logic               timed_out;
  logic               attempt_ok;
  logic               attempt_fail;

  assign ADDR    = DEV_ADDR;
  assign DataNum = 5'd0;

`ifdef SCCB_READBACK_VERIFY_EN
  logic rd_phase;

  always_comb begin
    attempt_ok = !NACK && (!rd_phase || (DATA_OUT == DATA_IN));
  end
`else
  logic unused_data_out;

  assign m_we            = 1'b1;
  assign unused_data_out = ^DATA_OUT;

  always_comb begin
    attempt_ok = !NACK;
  end
`endif

  // m_ready is only looked at once the controller has left idle, except to time out a stuck accept.
  always_comb begin
    timed_out    = (cnt == TO_LAST);
    attempt_fail = ((state == WAIT_ACCEPT) && m_ready && timed_out) ||
                   ((state == WAIT_DONE) && (m_ready ? !attempt_ok : timed_out));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
      rom_addr  <= '0;
      m_valid   <= 1'b0;
      REG       <= '0;
      DATA_IN   <= '0;
      retry     <= '0;
      cnt       <= '0;
`ifdef SCCB_READBACK_VERIFY_EN
      m_we      <= 1'b1;
      rd_phase  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the pre-edge values of state and counters.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= '0;
            retry    <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          if (rom_data == 16'hFFFF) begin
            state <= FINISH;
          end else if (rom_data[15:8] == 8'hFE) begin
            cnt   <= CNT_W'(rom_data[7:0]) * MS_K;
            state <= (rom_data[7:0] == 8'h00) ? NEXT : DELAY;
          end else begin
            REG     <= rom_data[15:8];
            DATA_IN <= rom_data[7:0];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          m_valid <= 1'b1;
          cnt     <= '0;
          state   <= WAIT_ACCEPT;
        end
        WAIT_ACCEPT: begin
          if (!m_ready) begin
            m_valid <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (m_ready && attempt_ok) begin
`ifdef SCCB_READBACK_VERIFY_EN
            if (!rd_phase) begin
              rd_phase <= 1'b1;
              m_we     <= 1'b0;
              state    <= ISSUE;
            end else begin
              rd_phase <= 1'b0;
              m_we     <= 1'b1;
              state    <= NEXT;
            end
`else
            state <= NEXT;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DELAY: begin
          if (cnt <= CNT_ONE) state <= NEXT;
          else                cnt   <= cnt - 1'b1;
        end
        NEXT: begin
          retry <= '0;
          if (rom_addr == LAST_IDX) begin
            state <= FINISH;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= FETCH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          error     <= 1'b1;
          err_index <= rom_addr;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // NOTE: placed after the case on purpose; a later non-blocking write wins, so a failed attempt
      // overrides whatever the wait-state branch scheduled.
      if (attempt_fail) begin
        m_valid <= 1'b0;
`ifdef SCCB_READBACK_VERIFY_EN
        rd_phase <= 1'b0;
        m_we     <= 1'b1;
`endif
        if (retry < RETRY_LIM) begin
          retry <= retry + 1'b1;
          state <= ISSUE;
        end else begin
          state <= FAIL;
        end
      end
    end
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Upstream master for i2c_controller: walks a register-init table (reg, data pairs) and issues one single-byte SCCB write per entry to the camera (OV7670/OV2640).
- Handles in-table delay markers, NACK retry, transaction timeout and end-of-table.
- Reports busy/done/error to the top-level camera bring-up logic.

Parameters:
- DEV_ADDR, 7'h21: 7-bit camera device address driven on ADDR (OV2640 builds use 7'h30).
- ROM_AW, 8: table address width; maximum 2^ROM_AW entries.
- MS_CYCLES, 50000: clk cycles per millisecond, used for delay entries.
- MAX_RETRY, 3: retries per entry after NACK or timeout before error.
- TIMEOUT_CYCLES, 65535: maximum clk cycles in any controller wait state.

Ports:
- clk  in  1  system clock, same clock as i2c_controller.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins the sequence from entry 0; ignored while busy.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle pulse on successful end-of-table.
- error  out  1  sticky until next accepted start; entry exhausted its retries.
- err_index  out  ROM_AW  entry index that failed; valid while error is high.
- rom_addr  out  ROM_AW  table read address.
- rom_data  in  16  {reg[15:8], data[7:0]}; synchronous ROM, valid 1 cycle after rom_addr.
- m_valid  out  1  transaction request to the controller.
- m_we  out  1  transaction direction; always 1.
- ADDR  out  7  device address; constant DEV_ADDR.
- REG  out  8  register address.
- DATA_IN  out  8  write data.
- DataNum  out  5  byte count minus 1; always 0.
- DATA_OUT  in  8  controller read data; used only with readback.
- m_ready  in  1  controller ready/complete.
- NACK  in  1  controller NACK flag; sampled at completion.

Behaviour:
- Reset values: busy=0, done=0, error=0, err_index=0, rom_addr=0, m_valid=0, m_we=1, REG=0, DATA_IN=0, DataNum=0. FSM goes to IDLE.
- Reset mid-transaction: m_valid drops immediately. The controller recovers through its own reset, which shares this reset source.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, NEXT, FINISH, FAIL.
- IDLE:
  - On start: idx=0, retry=0, error=0, busy=1 → FETCH.
- FETCH:
  - rom_addr=idx; wait 1 cycle → DECODE.
- DECODE:
  - rom_data==16'hFFFF → end of table → FINISH.
  - rom_data[15:8]==8'hFE → delay entry → DELAY, loading rom_data[7:0]*MS_CYCLES. A 0 ms delay passes straight through to NEXT in 1 cycle.
  - Otherwise: latch REG/DATA_IN → ISSUE. 8'hFF with data ≠ FF is a normal write (OV2640 bank select).
- ISSUE:
  - m_valid=1 → WAIT_ACCEPT; timeout counter cleared.
- WAIT_ACCEPT:
  - Hold m_valid and REG/DATA_IN stable until m_ready==0 is seen (controller has left idle).
  - Then m_valid=0 → WAIT_DONE.
  - m_ready is never trusted before acceptance.
- WAIT_DONE:
  - On first m_ready==1, sample NACK.
  - NACK==0 → NEXT.
  - NACK==1 and retry<MAX_RETRY → retry++, → ISSUE.
  - Otherwise → FAIL.
- Timeout: counter runs in WAIT_ACCEPT and WAIT_DONE. Reaching TIMEOUT_CYCLES is treated exactly as a NACK: m_valid=0, then retry or FAIL.
- NEXT:
  - idx++, retry=0 → FETCH.
  - If idx was 2^ROM_AW-1 (table with no terminator), wrap is forbidden: → FINISH.
- DELAY:
  - Count down to 0 → NEXT. m_valid stays 0 throughout.
- FINISH:
  - done=1 for one cycle, busy=0 → IDLE.
- FAIL:
  - error=1, err_index=idx, busy=0 → IDLE.
- A start pulse coinciding with FINISH or FAIL is ignored.
- Throughput: at most one outstanding transaction. Next FETCH begins 1 cycle after completion.

Optional Feature:
- Macro: SCCB_READBACK_VERIFY_EN.
- Defined:
  - After a successful write, the FSM issues a read of the same REG (m_we=0) through the same accept/done handshake.
  - It then compares DATA_OUT with the written data.
  - A mismatch counts as a failure (retry, then FAIL).
  - Delay and terminator entries are not verified.
- Undefined: no read path; m_we tied to 1 and DATA_OUT unused.

Test Plan:
- Table {12 80, FE 0A, 11 01, FFFF}, MS_CYCLES=10, controller model acks all → writes REG=0x12 DATA=0x80 then REG=0x11 DATA=0x01; ≥100-cycle gap between them with m_valid=0; single done pulse; busy low.
- Table with entry 1 NACKed twice then acked, MAX_RETRY=3 → entry 1 issued 3 times; done pulse; error=0.
- Entry 2 always NACKed, MAX_RETRY=3 → 4 attempts; error=1, err_index=2; no done pulse; later start clears error.
- Controller model never drops m_ready after m_valid, TIMEOUT_CYCLES=100 → m_valid released after 100 cycles; retries as NACK; final error=1.
- Assert rst low during WAIT_DONE of entry 3 → all outputs return to reset values asynchronously; new start restarts from entry 0.
- With SCCB_READBACK_VERIFY_EN: write 0x3A→0x04, model returns DATA_OUT=0x05 → retried; after retries exhausted error=1, err_index=0.
